// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the single-cycle CPU front end.
//   state_e    - step controller FSM state, 2-bit encoding shown on LEDs
//   PC_W_DEF   - default program-counter width
//   STEP_CNT_W - width of the saturating executed-step counter
package cpu_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;
    localparam int PC_W_DEF   = 8;
    localparam int STEP_CNT_W = 16;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces an active-low push-button and emits a press pulse.
//   iCLK    in  - system clock
//   iRST_N  in  - asynchronous active-low reset
//   key_n   in  - raw active-low key, asynchronous to iCLK
//   press   out - one-cycle registered pulse on each accepted 1->0 change of the debounced level
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic key_n,
    output logic press
);
    import cpu_pkg::*;
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [1:0]    sync_q;
    logic          stable_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic          synced;
    logic          accept;
    assign synced = sync_q[1];
    // The level has differed from the stable one for DEBOUNCE_CYCLES consecutive cycles.
    assign accept = (synced != stable_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    assign press  = press_q;
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q  <= {sync_q[0], key_n};
            press_q <= accept && !synced;
            if (synced == stable_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                stable_q <= synced;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end
endmodule

// File: rtl/step_fetch_ctrl.sv
// step_fetch_ctrl: owns the PC and issues one-cycle datapath step enables from a key or a run divider.
//   iCLK           in  - 50 MHz system clock
//   iRST_N         in  - asynchronous active-low reset
//   key_step_n     in  - raw active-low step key
//   run_en         in  - raw run-mode switch
//   pc_src         in  - select branch_target as next PC (sampled when step=1)
//   branch_target  in  - branch/jump target (sampled when step=1)
//   inst_halt      in  - current instruction is halt (sampled when step=1)
//   pc             out - current instruction address
//   pc_plus1       out - pc+1, combinational
//   step           out - one-cycle datapath write enable
//   state          out - FSM state for LEDs
//   step_count     out - saturating count of executed steps
module step_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RUN_DIV         = 25_000_000,
    parameter int PC_W            = PC_W_DEF
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  key_step_n,
    input  logic                  run_en,
    input  logic                  pc_src,
    input  logic [PC_W-1:0]       branch_target,
    input  logic                  inst_halt,
    output logic [PC_W-1:0]       pc,
    output logic [PC_W-1:0]       pc_plus1,
    output logic                  step,
    output logic [1:0]            state,
    output logic [STEP_CNT_W-1:0] step_count
);
    localparam int DW = RUN_DIV > 1 ? $clog2(RUN_DIV) : 1;
    logic                  press;
    logic [1:0]            run_sync_q;
    state_e                state_q;
    logic [PC_W-1:0]       pc_q;
    logic [PC_W-1:0]       pc_d;
    logic                  step_q;
    logic [STEP_CNT_W-1:0] cnt_q;
    logic [STEP_CNT_W-1:0] cnt_d;
    logic [DW-1:0]         div_q;
    logic                  run_s;
    logic                  div_tc;
    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .iCLK  (iCLK),
        .iRST_N(iRST_N),
        .key_n (key_step_n),
        .press (press)
    );
    assign run_s      = run_sync_q[1];
    assign div_tc     = div_q == DW'(RUN_DIV - 1);
    assign pc_plus1   = pc_q + PC_W'(1);
    assign pc         = pc_q;
    assign step       = step_q;
    assign state      = state_q;
    assign step_count = cnt_q;
    always_comb begin
        pc_d  = inst_halt ? pc_q : (pc_src ? branch_target : pc_plus1);
        cnt_d = &cnt_q ? cnt_q : cnt_q + STEP_CNT_W'(1);
    end
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            run_sync_q <= 2'b00;
            state_q    <= IDLE;
            pc_q       <= '0;
            step_q     <= 1'b0;
            cnt_q      <= '0;
            div_q      <= '0;
        end else begin
            run_sync_q <= {run_sync_q[0], run_en};
            step_q     <= 1'b0;
            if (step_q) begin
                pc_q  <= pc_d;
                cnt_q <= cnt_d;
            end
            // A halting step overrides whatever the current state would do next.
            if (step_q && inst_halt) begin
                state_q <= HALT;
                div_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        step_q <= press;
                        if (run_s) begin
                            state_q <= RUN;
                            div_q   <= '0;
                        end
                    end
                    RUN: begin
                        if (!run_s) begin
                            state_q <= IDLE;
                            div_q   <= '0;
                        end else if (div_tc) begin
                            step_q <= 1'b1;
                            div_q  <= '0;
                        end else begin
                            div_q <= div_q + DW'(1);
                        end
                    end
                    default: state_q <= HALT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_step_fetch_ctrl.sv
// tb_step_fetch_ctrl: directed self-checking bench for step_fetch_ctrl with short debounce and divider.
module tb_step_fetch_ctrl;
    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b1;
    logic        key_step_n = 1'b1;
    logic        run_en = 1'b0;
    logic        pc_src = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic        inst_halt = 1'b0;
    logic [7:0]  pc;
    logic [7:0]  pc_plus1;
    logic        step;
    logic [1:0]  state;
    logic [15:0] step_count;
    int passed = 0;
    int total = 0;
    int steps_seen = 0;
    step_fetch_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RUN_DIV(5),
        .PC_W(8)
    ) dut (
        .iCLK(iCLK),
        .iRST_N(iRST_N),
        .key_step_n(key_step_n),
        .run_en(run_en),
        .pc_src(pc_src),
        .branch_target(branch_target),
        .inst_halt(inst_halt),
        .pc(pc),
        .pc_plus1(pc_plus1),
        .step(step),
        .state(state),
        .step_count(step_count)
    );
    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) if (step === 1'b1) steps_seen <= steps_seen + 1;
    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask
    task automatic press(input logic [7:0] tgt, input logic src, input logic halt);
        branch_target = tgt;
        pc_src = src;
        inst_halt = halt;
        key_step_n = 1'b0;
        repeat (12) tick();
        key_step_n = 1'b1;
        repeat (12) tick();
        pc_src = 1'b0;
        inst_halt = 1'b0;
    endtask
    task automatic test_reset();
        #2 iRST_N = 1'b0;
        #1;
        total++; if (pc !== 8'h00) $display("FAIL reset_pc got %h exp 00", pc); else passed++;
        total++; if (pc_plus1 !== 8'h01) $display("FAIL reset_pc_plus1 got %h exp 01", pc_plus1); else passed++;
        total++; if (step !== 1'b0) $display("FAIL reset_step got %b exp 0", step); else passed++;
        total++; if (state !== 2'd0) $display("FAIL reset_state got %0d exp 0", state); else passed++;
        total++; if (step_count !== 16'd0) $display("FAIL reset_count got %0d exp 0", step_count); else passed++;
        repeat (2) tick();
        iRST_N = 1'b1;
        repeat (2) tick();
    endtask
    task automatic test_glitch();
        int s0;
        s0 = steps_seen;
        key_step_n = 1'b0;
        repeat (3) tick();
        key_step_n = 1'b1;
        repeat (15) tick();
        total++; if (steps_seen - s0 !== 0) $display("FAIL glitch_steps got %0d exp 0", steps_seen - s0); else passed++;
        total++; if (pc !== 8'h00) $display("FAIL glitch_pc got %h exp 00", pc); else passed++;
        total++; if (step_count !== 16'd0) $display("FAIL glitch_count got %0d exp 0", step_count); else passed++;
    endtask
    task automatic test_single_press();
        int s0;
        s0 = steps_seen;
        key_step_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (step !== (i == 6)) $display("FAIL press_latency after edge %0d step got %b exp %b", i, step, i == 6);
            else passed++;
        end
        repeat (12) tick();
        key_step_n = 1'b1;
        repeat (15) tick();
        total++; if (steps_seen - s0 !== 1) $display("FAIL press_steps got %0d exp 1", steps_seen - s0); else passed++;
        total++; if (pc !== 8'h01) $display("FAIL press_pc got %h exp 01", pc); else passed++;
        total++; if (pc_plus1 !== 8'h02) $display("FAIL press_pc_plus1 got %h exp 02", pc_plus1); else passed++;
        total++; if (step_count !== 16'd1) $display("FAIL press_count got %0d exp 1", step_count); else passed++;
    endtask
    task automatic test_branch();
        press(8'h20, 1'b1, 1'b0);
        total++; if (pc !== 8'h20) $display("FAIL branch_pc got %h exp 20", pc); else passed++;
        press(8'h77, 1'b0, 1'b0);
        total++; if (pc !== 8'h21) $display("FAIL branch_seq_pc got %h exp 21", pc); else passed++;
        press(8'hFE, 1'b1, 1'b0);
        total++; if (pc !== 8'hFE) $display("FAIL preload_pc got %h exp fe", pc); else passed++;
        total++; if (pc_plus1 !== 8'hFF) $display("FAIL preload_pc_plus1 got %h exp ff", pc_plus1); else passed++;
        total++; if (step_count !== 16'd4) $display("FAIL branch_count got %0d exp 4", step_count); else passed++;
    endtask
    task automatic test_run_wrap();
        bit ok;
        int highs;
        int s0;
        ok = 1'b0;
        run_en = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (step === 1'b1) ok = 1'b1;
        end
        total++; if (!ok) $display("FAIL run_first_step timeout step got 0 exp 1"); else passed++;
        total++; if (pc !== 8'hFE) $display("FAIL run_pc_during_step got %h exp fe", pc); else passed++;
        total++; if (state !== 2'd1) $display("FAIL run_state got %0d exp 1", state); else passed++;
        tick();
        total++; if (pc !== 8'hFF) $display("FAIL run_pc1 got %h exp ff", pc); else passed++;
        total++; if (pc_plus1 !== 8'h00) $display("FAIL run_pc_plus1_wrap got %h exp 00", pc_plus1); else passed++;
        highs = 0;
        for (int i = 0; i < 4; i++) begin
            if (step !== 1'b0) highs++;
            tick();
        end
        total++; if (highs !== 0) $display("FAIL run_gap got %0d steps exp 0", highs); else passed++;
        total++; if (step !== 1'b1) $display("FAIL run_period step got %b exp 1", step); else passed++;
        tick();
        total++; if (pc !== 8'h00) $display("FAIL run_wrap_pc got %h exp 00", pc); else passed++;
        run_en = 1'b0;
        repeat (4) tick();
        total++; if (state !== 2'd0) $display("FAIL run_stop_state got %0d exp 0", state); else passed++;
        s0 = steps_seen;
        repeat (15) tick();
        total++; if (steps_seen - s0 !== 0) $display("FAIL run_stop_steps got %0d exp 0", steps_seen - s0); else passed++;
        total++; if (pc !== 8'h00) $display("FAIL run_stop_pc got %h exp 00", pc); else passed++;
        total++; if (step_count !== 16'd6) $display("FAIL run_count got %0d exp 6", step_count); else passed++;
    endtask
    task automatic test_halt();
        int s0;
        press(8'h05, 1'b1, 1'b0);
        total++; if (pc !== 8'h05) $display("FAIL halt_setup_pc got %h exp 05", pc); else passed++;
        press(8'h40, 1'b1, 1'b1);
        total++; if (state !== 2'd2) $display("FAIL halt_state got %0d exp 2", state); else passed++;
        total++; if (pc !== 8'h05) $display("FAIL halt_pc got %h exp 05", pc); else passed++;
        total++; if (step_count !== 16'd8) $display("FAIL halt_count got %0d exp 8", step_count); else passed++;
        s0 = steps_seen;
        press(8'h40, 1'b1, 1'b0);
        run_en = 1'b1;
        repeat (20) tick();
        total++; if (steps_seen - s0 !== 0) $display("FAIL halt_frozen_steps got %0d exp 0", steps_seen - s0); else passed++;
        total++; if (state !== 2'd2) $display("FAIL halt_hold_state got %0d exp 2", state); else passed++;
        total++; if (pc !== 8'h05) $display("FAIL halt_hold_pc got %h exp 05", pc); else passed++;
        run_en = 1'b0;
    endtask
    task automatic test_async_reset();
        bit ok;
        iRST_N = 1'b0;
        tick();
        iRST_N = 1'b1;
        tick();
        press(8'h10, 1'b1, 1'b0);
        run_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            if (state === 2'd1) ok = 1'b1;
        end
        total++; if (!ok) $display("FAIL arst_enter_run timeout state got %0d exp 1", state); else passed++;
        repeat (2) tick();
        total++; if (pc !== 8'h10) $display("FAIL arst_setup_pc got %h exp 10", pc); else passed++;
        total++; if (step_count !== 16'd1) $display("FAIL arst_setup_count got %0d exp 1", step_count); else passed++;
        #2 iRST_N = 1'b0;
        #1;
        total++; if (pc !== 8'h00) $display("FAIL arst_pc got %h exp 00", pc); else passed++;
        total++; if (state !== 2'd0) $display("FAIL arst_state got %0d exp 0", state); else passed++;
        total++; if (step !== 1'b0) $display("FAIL arst_step got %b exp 0", step); else passed++;
        total++; if (step_count !== 16'd0) $display("FAIL arst_count got %0d exp 0", step_count); else passed++;
        run_en = 1'b0;
        tick();
        iRST_N = 1'b1;
        repeat (3) tick();
        total++; if (state !== 2'd0) $display("FAIL arst_after_state got %0d exp 0", state); else passed++;
    endtask
    initial begin
        test_reset();
        test_glitch();
        test_single_press();
        test_branch();
        test_run_wrap();
        test_halt();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
